// File: rtl/seq_detector.sv
// Parametrised serial pattern detector, Mealy or Moore output, overlapping or not.
// Define SEQDET_COUNT_EN to build the saturating match counter; otherwise match_count is tied to zero.
module seq_detector #(
  parameter int unsigned          PATTERN_W = 4,
  parameter logic [PATTERN_W-1:0] PATTERN   = 4'b1011,
  parameter bit                   MOORE     = 1'b0,
  parameter bit                   OVERLAP   = 1'b1,
  parameter int unsigned          CNT_W     = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  input  logic             x,
  input  logic             clear,
  output logic             match,
  output logic [CNT_W-1:0] match_count
);

  localparam logic [4:0] FILL_MAX = 5'(PATTERN_W - 1);

  logic [PATTERN_W-2:0] hist;
  logic [4:0]           fill;
  logic [PATTERN_W-1:0] window;
  logic                 accept;
  logic                 hit;

  // The compare window includes the bit currently on x, so the Mealy match is zero-latency.
  assign window = {hist, x};
  assign accept = in_valid & ~clear;
  assign hit    = accept & (fill == FILL_MAX) & (window == PATTERN);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      hist <= '0;
      fill <= '0;
    end else if (clear) begin
      fill <= '0;
    end else if (in_valid) begin
      hist <= window[PATTERN_W-2:0];
      if (hit && !OVERLAP) begin
        fill <= '0;
      end else if (fill != FILL_MAX) begin
        fill <= fill + 5'd1;
      end
    end
  end

  generate
    if (MOORE) begin : g_moore
      logic match_q;

      always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
          match_q <= 1'b0;
        end else begin
          match_q <= hit;
        end
      end

      assign match = match_q;
    end else begin : g_mealy
      assign match = hit;
    end
  endgenerate

`ifdef SEQDET_COUNT_EN
  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt <= '0;
    end else if (hit && (cnt != '1)) begin
      cnt <= cnt + 1'b1;
    end
  end

  assign match_count = cnt;
`else
  assign match_count = '0;
`endif

endmodule

// File: tb/tb_seq_detector.sv
// Directed bench for seq_detector: four instances (Mealy/Moore, overlap/non-overlap, 1111 saturation)
// share one stimulus stream; expected values are hand-computed in the vector table.
module tb_seq_detector;

`ifdef SEQDET_COUNT_EN
  localparam bit CNT_EN = 1'b1;
`else
  localparam bit CNT_EN = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       in_valid = 1'b0;
  logic       x = 1'b0;
  logic       clear = 1'b0;
  logic       match_a, match_b, match_c, match_d;
  logic [7:0] count_a, count_b, count_c;
  logic [1:0] count_d;

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  seq_detector #(.PATTERN_W(4), .PATTERN(4'b1011), .MOORE(1'b0), .OVERLAP(1'b1), .CNT_W(8)) dut_a (
    .clk(clk), .reset(reset), .in_valid(in_valid), .x(x), .clear(clear),
    .match(match_a), .match_count(count_a));

  seq_detector #(.PATTERN_W(4), .PATTERN(4'b1011), .MOORE(1'b1), .OVERLAP(1'b1), .CNT_W(8)) dut_b (
    .clk(clk), .reset(reset), .in_valid(in_valid), .x(x), .clear(clear),
    .match(match_b), .match_count(count_b));

  seq_detector #(.PATTERN_W(4), .PATTERN(4'b1011), .MOORE(1'b0), .OVERLAP(1'b0), .CNT_W(8)) dut_c (
    .clk(clk), .reset(reset), .in_valid(in_valid), .x(x), .clear(clear),
    .match(match_c), .match_count(count_c));

  seq_detector #(.PATTERN_W(4), .PATTERN(4'b1111), .MOORE(1'b1), .OVERLAP(1'b1), .CNT_W(2)) dut_d (
    .clk(clk), .reset(reset), .in_valid(in_valid), .x(x), .clear(clear),
    .match(match_d), .match_count(count_d));

  typedef struct {
    logic v;
    logic b;
    logic c;
    logic ea;
    logic eb;
    logic ec;
  } vec_t;

  function automatic vec_t mk(input logic v, input logic b, input logic c,
                              input logic ea, input logic eb, input logic ec);
    vec_t r;
    r.v = v; r.b = b; r.c = c; r.ea = ea; r.eb = eb; r.ec = ec;
    return r;
  endfunction

  task automatic chk(input string name, input int row, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      $display("FAIL %s (step %0d): got %0d, expected %0d", name, row, act, exp);
    end else begin
      n_pass++;
    end
  endtask

  // Inputs change on the falling edge; outputs are sampled 1 time unit later, well before the rising edge.
  task automatic drive(input logic v, input logic b, input logic c);
    @(negedge clk);
    in_valid = v;
    x        = b;
    clear    = c;
    #1;
  endtask

  function automatic logic [31:0] cexp(input int model);
    return CNT_EN ? 32'(model) : 32'd0;
  endfunction

  vec_t tbl[26];
  int   cnt_a;
  int   cnt_c;
  logic [8:0] d_match_exp;
  int   d_cnt_exp[9];

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    //               v  x  clr  A  B  C
    tbl[0]  = mk(1, 1, 0,  0, 0, 0);
    tbl[1]  = mk(1, 0, 0,  0, 0, 0);
    tbl[2]  = mk(1, 1, 0,  0, 0, 0);
    tbl[3]  = mk(1, 1, 0,  1, 0, 1);  // 1011 complete
    tbl[4]  = mk(1, 0, 0,  0, 1, 0);
    tbl[5]  = mk(1, 1, 0,  0, 0, 0);
    tbl[6]  = mk(1, 1, 0,  1, 0, 0);  // overlapped match only
    tbl[7]  = mk(1, 1, 1,  0, 1, 0);  // clear
    tbl[8]  = mk(1, 1, 0,  0, 0, 0);
    tbl[9]  = mk(1, 0, 0,  0, 0, 0);
    tbl[10] = mk(0, 1, 0,  0, 0, 0);  // valid gap
    tbl[11] = mk(0, 1, 0,  0, 0, 0);
    tbl[12] = mk(0, 1, 0,  0, 0, 0);
    tbl[13] = mk(1, 1, 0,  0, 0, 0);
    tbl[14] = mk(1, 1, 0,  1, 0, 1);
    tbl[15] = mk(1, 1, 1,  0, 1, 0);  // clear
    tbl[16] = mk(1, 1, 0,  0, 0, 0);
    tbl[17] = mk(1, 0, 0,  0, 0, 0);
    tbl[18] = mk(1, 1, 0,  0, 0, 0);
    tbl[19] = mk(1, 1, 1,  0, 0, 0);  // clear would otherwise complete 1011
    tbl[20] = mk(1, 1, 0,  0, 0, 0);
    tbl[21] = mk(1, 0, 0,  0, 0, 0);
    tbl[22] = mk(1, 1, 0,  0, 0, 0);
    tbl[23] = mk(1, 1, 0,  1, 0, 1);
    tbl[24] = mk(0, 0, 0,  0, 1, 0);  // Moore pulse unaffected by in_valid
    tbl[25] = mk(0, 0, 0,  0, 0, 0);

    // Reset state
    #2 reset = 1'b1;
    #1;
    chk("reset_match_a", 0, 32'(match_a), 32'd0);
    chk("reset_match_b", 0, 32'(match_b), 32'd0);
    chk("reset_match_c", 0, 32'(match_c), 32'd0);
    chk("reset_match_d", 0, 32'(match_d), 32'd0);
    chk("reset_count_a", 0, 32'(count_a), 32'd0);
    chk("reset_count_d", 0, 32'(count_d), 32'd0);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;

    cnt_a = 0;
    cnt_c = 0;
    for (int i = 0; i < 26; i++) begin
      drive(tbl[i].v, tbl[i].b, tbl[i].c);
      chk("tbl_match_a", i + 1, 32'(match_a), 32'(tbl[i].ea));
      chk("tbl_match_b", i + 1, 32'(match_b), 32'(tbl[i].eb));
      chk("tbl_match_c", i + 1, 32'(match_c), 32'(tbl[i].ec));
      chk("tbl_count_a", i + 1, 32'(count_a), cexp(cnt_a));
      chk("tbl_count_b", i + 1, 32'(count_b), cexp(cnt_a));
      chk("tbl_count_c", i + 1, 32'(count_c), cexp(cnt_c));
      if (tbl[i].ea) cnt_a++;
      if (tbl[i].ec) cnt_c++;
    end

    // Asynchronous reset while a Mealy match is being presented
    drive(1, 1, 0);
    drive(1, 0, 0);
    drive(1, 1, 0);
    drive(1, 1, 0);
    chk("pre_areset_match_a", 101, 32'(match_a), 32'd1);
    chk("pre_areset_match_c", 101, 32'(match_c), 32'd1);
    chk("pre_areset_count_a", 101, 32'(count_a), cexp(4));
    #2 reset = 1'b1;
    #1;
    chk("areset_match_a", 102, 32'(match_a), 32'd0);
    chk("areset_match_c", 102, 32'(match_c), 32'd0);
    chk("areset_count_a", 102, 32'(count_a), 32'd0);
    chk("areset_count_c", 102, 32'(count_c), 32'd0);
    @(negedge clk);
    reset = 1'b0;

    // First match after reset needs four fresh bits
    drive(1, 1, 0);
    chk("post_reset_bit1_a", 103, 32'(match_a), 32'd0);
    drive(1, 0, 0);
    drive(1, 1, 0);
    chk("post_reset_bit3_a", 104, 32'(match_a), 32'd0);
    drive(1, 1, 0);
    chk("post_reset_bit4_a", 105, 32'(match_a), 32'd1);
    chk("post_reset_bit4_b", 105, 32'(match_b), 32'd0);

    // Asynchronous reset while the Moore pulse is high
    drive(0, 0, 0);
    chk("pre_areset_match_b", 106, 32'(match_b), 32'd1);
    chk("pre_areset_count_b", 106, 32'(count_b), cexp(1));
    #1 reset = 1'b1;
    #1;
    chk("areset_match_b", 107, 32'(match_b), 32'd0);
    chk("areset_count_b", 107, 32'(count_b), 32'd0);
    @(negedge clk);
    reset = 1'b0;

    // 1111, overlap, Moore, 2-bit saturating counter: seven 1s then idle
    d_match_exp  = 9'b011110000;
    d_cnt_exp    = '{0, 0, 0, 0, 1, 2, 3, 3, 3};
    for (int k = 0; k < 9; k++) begin
      drive(k < 7 ? 1'b1 : 1'b0, k < 7 ? 1'b1 : 1'b0, 1'b0);
      chk("ones_match_d", 200 + k, 32'(match_d), 32'(d_match_exp[k]));
      chk("ones_count_d", 200 + k, 32'(count_d), cexp(d_cnt_exp[k]));
      chk("ones_match_a", 200 + k, 32'(match_a), 32'd0);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
